fifo_ctrl: RTL and testbench
============================

// Module: fifo_ctrl
// PURPOSE
//  Control unit of the synchronous FIFO. Owns head/tail pointers, occupancy count and status flags.
//  Drives the 8x32 register file write port (we, wAddr) and read address (rAddr).
//  Registers the returned read data onto d_out and handshakes with one producer and one consumer.
//  Sits beside the register file inside the FIFO top.
// PARAMETERS
//  DW  32  data width (must match register file)
//  AW  3   address width; DEPTH = 2**AW = 8 entries
// PORTS
//  clk        in   1     single clock, all state on rising edge
//  reset_n    in   1     asynchronous, active-low reset
//  wr_en      in   1     producer write request
//  rd_en      in   1     consumer read request
//  rf_rData   in   DW    combinational read data from register file (addressed by rAddr)
//  we         out  1     register file write enable
//  wAddr      out  AW    register file write address (= tail)
//  rAddr      out  AW    register file read address (= head)
//  d_out      out  DW    registered read data
//  full       out  1     count == DEPTH
//  empty      out  1     count == 0
//  wr_ack     out  1     1-cycle pulse: previous-cycle write accepted
//  wr_err     out  1     1-cycle pulse: previous-cycle write refused (full)
//  rd_ack     out  1     1-cycle pulse: previous-cycle read accepted, d_out valid
//  rd_err     out  1     1-cycle pulse: previous-cycle read refused (empty)
//  data_count out  AW+1  occupancy 0..DEPTH
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=INIT, head=tail=0, data_count=0, d_out=0, empty=1, full=0,
//    all ack/err=0. Any in-flight request is dropped; the register file contents are ignored.
//  - Request acceptance is evaluated combinationally on current flags:
//    wr_ok = wr_en & (~full | rd_ok_simul); rd_ok = rd_en & ~empty.
//  - Simultaneous requests:
//    - Not empty and not full: both accepted; count unchanged.
//    - Empty: write accepted; read refused (rd_err).
//    - Full: read accepted; write also accepted (slot freed same edge), count unchanged.
//  - Accepted write: we=1 combinationally in the same cycle, wAddr=tail. At the clock edge the
//    register file stores the data and tail <= tail+1 (mod DEPTH wrap 7->0).
//  - Accepted read: rAddr=head. At the clock edge d_out <= rf_rData and head <= head+1 (mod DEPTH).
//    Read latency: data on d_out the cycle after rd_en, qualified by rd_ack.
//  - we is 0 whenever the write is not accepted; no register-file write occurs on refusal.
//  - data_count is +1 on write-only, -1 on read-only, unchanged on both or neither.
//    It never exceeds DEPTH and never goes below 0.
//  - full/empty are decoded from the registered data_count (valid from the cycle after the update).
//  - FSM state register, next state from current inputs and flags:
//    - INIT     : after reset; behaves as NO_OP.
//    - NO_OP    : no request.
//    - WRITE    : write-only accepted.
//    - READ     : read-only accepted (d_out updated).
//    - WR_RD    : both accepted.
//    - WR_ERROR : write refused, no accepted read.
//    - RD_ERROR : read refused (empty), no write.
//    - Empty with both requested: WRITE state, and rd_err is also pulsed.
//  - Ack/err flags are registered Moore outputs of the state: each is high for exactly one cycle
//    per request cycle; the same request held N cycles gives N pulses.
//  - d_out holds its last value when no read is accepted, including on rd_err.
// STRUCTURE
//  - fifo_ctrl_pkg: state encoding localparams (INIT..RD_ERROR, 3 bits), DEPTH derivation.
//  - One sub-module, fifo_ctrl_ns: combinational next-state, next-pointer and next-count logic.
//  - fifo_ctrl keeps the registers and output decode.
//  - The FIFO top instantiates fifo_ctrl plus the register file; wData passes straight through.
// TESTING
//  1. Reset, idle -> empty=1, full=0, data_count=0, d_out=0, no ack/err; reset_n low mid-write
//     -> immediate return to these values.
//  2. 8 writes of 0x11..0x88 -> 8 wr_ack, data_count=8, full=1; 9th write -> wr_err, we=0, tail=0.
//  3. From full, 8 reads -> d_out 0x11..0x88 in order with rd_ack, empty=1; 9th read -> rd_err,
//     d_out stays 0x88.
//  4. Wrap: write 5, read 5, write 6 -> wAddr sequence 5,6,7,0,1,2; reads return data in order.
//  5. Simultaneous wr/rd at count=3 -> wr_ack & rd_ack, count stays 3; at empty -> wr_ack + rd_err,
//     count=1.
//  6. Simultaneous wr/rd at full -> read data = oldest entry, write stored at old head slot,
//     count stays 8, full stays 1.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg
//   Shared definitions for the FIFO control unit: default geometry and the
//   3-bit FSM state encoding used by fifo_ctrl and fifo_ctrl_ns.
package fifo_ctrl_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 3;
  localparam int DEPTH_DEF = 1 << AW_DEF;

  typedef enum logic [2:0] {
    INIT     = 3'd0,
    NO_OP    = 3'd1,
    WRITE    = 3'd2,
    READ     = 3'd3,
    WR_RD    = 3'd4,
    WR_ERROR = 3'd5,
    RD_ERROR = 3'd6
  } state_e;

endpackage

// File: rtl/fifo_ctrl_ns.sv
// fifo_ctrl_ns
//   Combinational next-state logic of the FIFO control unit: request
//   acceptance, next FSM state, next head/tail pointers and next count.
// Ports
//   wr_en, rd_en    producer / consumer requests
//   full, empty     flags decoded from the registered count
//   head_q, tail_q  current read / write pointers
//   count_q         current occupancy
//   wr_ok, rd_ok    request accepted this cycle
//   wr_refused      write requested but refused (full, no read alongside)
//   rd_refused      read requested but refused (empty)
//   state_d         next FSM state
//   head_d, tail_d  next pointers
//   count_d         next occupancy
module fifo_ctrl_ns
  import fifo_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic          full,
  input  logic          empty,
  input  logic [AW-1:0] head_q,
  input  logic [AW-1:0] tail_q,
  input  logic [AW:0]   count_q,
  output logic          wr_ok,
  output logic          rd_ok,
  output logic          wr_refused,
  output logic          rd_refused,
  output state_e        state_d,
  output logic [AW-1:0] head_d,
  output logic [AW-1:0] tail_d,
  output logic [AW:0]   count_d
);

  always_comb begin
    // A read that is accepted in the same cycle frees a slot, so a write
    // into a full FIFO can still be taken alongside it.
    rd_ok      = rd_en & ~empty;
    wr_ok      = wr_en & (~full | rd_ok);
    wr_refused = wr_en & ~wr_ok;
    rd_refused = rd_en & ~rd_ok;

    // Pointers are exactly AW bits wide, so +1 wraps DEPTH-1 -> 0.
    head_d  = rd_ok ? head_q + AW'(1) : head_q;
    tail_d  = wr_ok ? tail_q + AW'(1) : tail_q;

    count_d = count_q;
    if (wr_ok && !rd_ok) begin
      count_d = count_q + (AW+1)'(1);
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - (AW+1)'(1);
    end

    // Empty with both requested lands in WRITE; the refused read is
    // reported separately through rd_refused.
    if (wr_ok && rd_ok) begin
      state_d = WR_RD;
    end else if (wr_ok) begin
      state_d = WRITE;
    end else if (rd_ok) begin
      state_d = READ;
    end else if (wr_refused) begin
      state_d = WR_ERROR;
    end else if (rd_refused) begin
      state_d = RD_ERROR;
    end else begin
      state_d = NO_OP;
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl
//   Control unit of a synchronous FIFO that sits beside an external
//   2**AW x DW register file. Owns head/tail pointers, occupancy count,
//   status flags, registered read data and the ack/err handshake pulses.
// Ports
//   clk         clock, all state on the rising edge
//   reset_n     asynchronous active-low reset
//   wr_en       producer write request
//   rd_en       consumer read request
//   rf_rData    combinational register file read data at rAddr
//   we          register file write enable (accepted write, same cycle)
//   wAddr       register file write address (tail)
//   rAddr       register file read address (head)
//   d_out       registered read data
//   full        count == DEPTH
//   empty       count == 0
//   wr_ack      pulse: previous-cycle write accepted
//   wr_err      pulse: previous-cycle write refused
//   rd_ack      pulse: previous-cycle read accepted, d_out valid
//   rd_err      pulse: previous-cycle read refused
//   data_count  occupancy 0..DEPTH
//   dbg_state   current FSM state
//
// Handshake: a request held high on wr_en/rd_en is evaluated every cycle
// against the current flags; each request cycle yields exactly one
// ack or err pulse on the following cycle, and d_out is valid while
// rd_ack is high. There is no back-pressure beyond the err pulses.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [DW-1:0] rf_rData,
  output logic          we,
  output logic [AW-1:0] wAddr,
  output logic [AW-1:0] rAddr,
  output logic [DW-1:0] d_out,
  output logic          full,
  output logic          empty,
  output logic          wr_ack,
  output logic          wr_err,
  output logic          rd_ack,
  output logic          rd_err,
  output logic [AW:0]   data_count,
  output state_e        dbg_state
);

  localparam logic [AW:0] DEPTH_CNT = {1'b1, {AW{1'b0}}};

  state_e        state_q, state_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic [DW-1:0] dout_q;
  logic          wr_ack_q, wr_err_q, rd_ack_q, rd_err_q;

  logic wr_ok, rd_ok, wr_refused, rd_refused;
  logic full_w, empty_w;

  assign full_w  = (count_q == DEPTH_CNT);
  assign empty_w = (count_q == '0);

  fifo_ctrl_ns #(.AW(AW)) u_ns (
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .full       (full_w),
    .empty      (empty_w),
    .head_q     (head_q),
    .tail_q     (tail_q),
    .count_q    (count_q),
    .wr_ok      (wr_ok),
    .rd_ok      (rd_ok),
    .wr_refused (wr_refused),
    .rd_refused (rd_refused),
    .state_d    (state_d),
    .head_d     (head_d),
    .tail_d     (tail_d),
    .count_d    (count_d)
  );

  // FSM plus datapath registers. Ack/err are registered alongside the
  // state so they are clean one-cycle pulses per request cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= INIT;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      wr_ack_q <= 1'b0;
      wr_err_q <= 1'b0;
      rd_ack_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      if (rd_ok) begin
        dout_q <= rf_rData;
      end
      wr_ack_q <= (state_d == WRITE) || (state_d == WR_RD);
      wr_err_q <= (state_d == WR_ERROR);
      rd_ack_q <= (state_d == READ) || (state_d == WR_RD);
      // Covers RD_ERROR and the empty-with-both case that sits in WRITE.
      rd_err_q <= rd_refused;
    end
  end

  assign we         = wr_ok;
  assign wAddr      = tail_q;
  assign rAddr      = head_q;
  assign d_out      = dout_q;
  assign full       = full_w;
  assign empty      = empty_w;
  assign wr_ack     = wr_ack_q;
  assign wr_err     = wr_err_q;
  assign rd_ack     = rd_ack_q;
  assign rd_err     = rd_err_q;
  assign data_count = count_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
module tb_fifo_ctrl;
  import fifo_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        wr_en, rd_en;
  logic [31:0] wdata;
  logic [31:0] rf_rData;
  logic        we;
  logic [2:0]  wAddr, rAddr;
  logic [31:0] d_out;
  logic        full, empty, wr_ack, wr_err, rd_ack, rd_err;
  logic [3:0]  data_count;
  state_e      dbg_state;

  fifo_ctrl #(.DW(32), .AW(3)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .rf_rData   (rf_rData),
    .we         (we),
    .wAddr      (wAddr),
    .rAddr      (rAddr),
    .d_out      (d_out),
    .full       (full),
    .empty      (empty),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err),
    .data_count (data_count),
    .dbg_state  (dbg_state)
  );

  // Register file beside the controller: write on clock edge, combinational read.
  logic [31:0] mem [8];
  initial for (int i = 0; i < 8; i++) mem[i] = 32'h0;
  always @(posedge clk) if (we) mem[wAddr] <= wdata;
  assign rf_rData = mem[rAddr];

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  // {wr_ack, wr_err, rd_ack, rd_err, d_out}
  logic [35:0] exp_q[$];
  logic [31:0] model_q[$];
  logic [31:0] last_dout;
  logic [2:0]  m_head, m_tail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    last_dout = 32'h0;
    m_head = 3'd0;
    m_tail = 3'd0;
  endtask

  // ---------------- driver tasks ----------------
  // One request cycle. exp_wa >= 0 adds a directed check of wAddr.
  task automatic req(input logic wr, input logic rd, input logic [31:0] wd, input int exp_wa);
    bit em, fu, rok, wok;
    @(negedge clk);
    wr_en = wr;
    rd_en = rd;
    wdata = wd;
    em  = (model_q.size() == 0);
    fu  = (model_q.size() == 8);
    rok = rd && !em;
    wok = wr && (!fu || rok);
    #1;
    chk("we", {31'b0, we}, {31'b0, wok});
    if (wok) chk("wAddr", {29'b0, wAddr}, {29'b0, m_tail});
    if (rd)  chk("rAddr", {29'b0, rAddr}, {29'b0, m_head});
    if (exp_wa >= 0) chk("wAddr_dir", {29'b0, wAddr}, exp_wa[31:0]);
    if (rok) begin
      last_dout = model_q.pop_front();
      m_head++;
    end
    if (wok) begin
      model_q.push_back(wd);
      m_tail++;
    end
    if (wr || rd) exp_q.push_back({wok, wr && !wok, rok, rd && !rok, last_dout});
  endtask

  task automatic idle();
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #1;
  endtask

  task automatic chk_status(input string name, input logic [3:0] cnt, input logic f, input logic e);
    chk({name, "_count"}, {28'b0, data_count}, {28'b0, cnt});
    chk({name, "_full"},  {31'b0, full},  {31'b0, f});
    chk({name, "_empty"}, {31'b0, empty}, {31'b0, e});
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_pulses"}, {28'b0, wr_ack, wr_err, rd_ack, rd_err}, 32'h0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [35:0] e;
    if (reset_n === 1'b1 && (wr_ack || wr_err || rd_ack || rd_err)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse actual=%b%b%b%b required=none",
                 wr_ack, wr_err, rd_ack, rd_err);
      end else begin
        e = exp_q.pop_front();
        if ({wr_ack, wr_err, rd_ack, rd_err} !== e[35:32] || d_out !== e[31:0]) begin
          errors++;
          $display("FAIL response actual=%b%b%b%b/0x%0h required=%b%b%b%b/0x%0h",
                   wr_ack, wr_err, rd_ack, rd_err, d_out,
                   e[35], e[34], e[33], e[32], e[31:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int wa [6];
    wa = '{5, 6, 7, 0, 1, 2};
    reset_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wdata = 32'h0;
    model_reset();

    // 1. Reset and idle
    repeat (2) @(negedge clk);
    #1;
    chk_status("reset", 4'd0, 1'b0, 1'b1);
    chk("reset_dout", d_out, 32'h0);
    chk_quiet("reset");
    chk("reset_state", {29'b0, dbg_state}, {29'b0, INIT});
    @(negedge clk);
    reset_n = 1'b1;
    idle();
    idle();
    chk_status("idle", 4'd0, 1'b0, 1'b1);
    chk_quiet("idle");
    chk("idle_state", {29'b0, dbg_state}, {29'b0, NO_OP});

    // Reset asserted mid-write with state and d_out non-zero
    req(1'b1, 1'b0, 32'hAA, -1);
    req(1'b1, 1'b0, 32'hBB, -1);
    req(1'b0, 1'b1, 32'h0, -1);
    @(negedge clk);
    wr_en = 1'b1;
    rd_en = 1'b0;
    wdata = 32'hCC;
    #2;
    reset_n = 1'b0;
    #1;
    chk_status("midrst", 4'd0, 1'b0, 1'b1);
    chk("midrst_dout", d_out, 32'h0);
    chk_quiet("midrst");
    model_reset();
    @(negedge clk);
    wr_en = 1'b0;
    reset_n = 1'b1;

    // 2. Fill with 0x11..0x88, then one refused write
    for (int i = 0; i < 8; i++) req(1'b1, 1'b0, 32'h11 * (i + 1), i);
    idle();
    chk_status("fill", 4'd8, 1'b1, 1'b0);
    req(1'b1, 1'b0, 32'h99, 0);
    idle();
    chk_status("overflow", 4'd8, 1'b1, 1'b0);

    // 3. Drain in order, then one refused read
    for (int i = 0; i < 8; i++) req(1'b0, 1'b1, 32'h0, -1);
    idle();
    chk_status("drain", 4'd0, 1'b0, 1'b1);
    chk("drain_last", d_out, 32'h88);
    req(1'b0, 1'b1, 32'h0, -1);
    idle();
    chk("underflow_dout", d_out, 32'h88);

    // 4. Pointer wrap
    for (int i = 0; i < 5; i++) req(1'b1, 1'b0, 32'h100 + i, -1);
    for (int i = 0; i < 5; i++) req(1'b0, 1'b1, 32'h0, -1);
    for (int i = 0; i < 6; i++) req(1'b1, 1'b0, 32'h200 + i, wa[i]);
    for (int i = 0; i < 6; i++) req(1'b0, 1'b1, 32'h0, -1);
    idle();
    chk("wrap_last", d_out, 32'h205);
    chk_status("wrap", 4'd0, 1'b0, 1'b1);

    // 5. Simultaneous requests at count=3 and at empty
    for (int i = 0; i < 3; i++) req(1'b1, 1'b0, 32'h500 + i, -1);
    req(1'b1, 1'b1, 32'h503, -1);
    idle();
    chk_status("simul3", 4'd3, 1'b0, 1'b0);
    chk("simul3_dout", d_out, 32'h500);
    for (int i = 0; i < 3; i++) req(1'b0, 1'b1, 32'h0, -1);
    idle();
    chk_status("pre_simul0", 4'd0, 1'b0, 1'b1);
    req(1'b1, 1'b1, 32'h5AA, -1);
    idle();
    chk_status("simul0", 4'd1, 1'b0, 1'b0);
    req(1'b0, 1'b1, 32'h0, -1);
    idle();
    chk("simul0_read", d_out, 32'h5AA);

    // 6. Simultaneous requests at full
    for (int i = 0; i < 8; i++) req(1'b1, 1'b0, 32'h601 + i, -1);
    req(1'b1, 1'b1, 32'h6FF, -1);
    idle();
    chk_status("simul8", 4'd8, 1'b1, 1'b0);
    chk("simul8_dout", d_out, 32'h601);
    for (int i = 0; i < 8; i++) req(1'b0, 1'b1, 32'h0, -1);
    idle();
    chk("simul8_last", d_out, 32'h6FF);
    chk_status("final", 4'd0, 1'b0, 1'b1);

    repeat (2) idle();
    chk("pending_responses", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
